// File: rtl/reservation_station_pkg.sv
// reservation_station_pkg: shared widths, entry/packet types and operand capture helpers.
package reservation_station_pkg;
  localparam int RS_SIZE_DEF = 4;
  localparam int PAYLOAD_W = 32;
  localparam int ROB_TAG_LEN = 5;
  localparam int XLEN = 64;
  // ROB tag 0 is never allocated: it marks an operand that lives in the register file
  localparam logic [ROB_TAG_LEN-1:0] ROB_TAG_NONE = '0;
  typedef struct packed {
    logic [ROB_TAG_LEN-1:0] rob_tag_val;
    logic                   rob_tag_ready;
  } maptable_packet_t;
  typedef struct packed {
    logic [ROB_TAG_LEN-1:0] tag;
    logic                   ready;
    logic [XLEN-1:0]        value;
  } rs_operand_t;
  typedef struct packed {
    logic                   valid;
    logic                   spec;
    logic [PAYLOAD_W-1:0]   op;
    logic [ROB_TAG_LEN-1:0] rob;
    rs_operand_t            src1;
    rs_operand_t            src2;
  } rs_entry_t;
  typedef struct packed {
    logic [PAYLOAD_W-1:0]   op;
    logic [ROB_TAG_LEN-1:0] rob;
    logic [XLEN-1:0]        rs1_value;
    logic [XLEN-1:0]        rs2_value;
  } rs_issue_packet_t;
  function automatic rs_operand_t dispatch_operand(input maptable_packet_t map,
                                                   input logic [XLEN-1:0] rf_value,
                                                   input logic cdb_valid,
                                                   input logic [ROB_TAG_LEN-1:0] cdb_tag,
                                                   input logic [XLEN-1:0] cdb_value);
    rs_operand_t o;
    logic rf_ok, fwd;
    rf_ok = (map.rob_tag_val == ROB_TAG_NONE) || map.rob_tag_ready;
    fwd = cdb_valid && (cdb_tag == map.rob_tag_val);
    o.tag = map.rob_tag_val;
    o.ready = rf_ok || fwd;
    o.value = rf_ok ? rf_value : (fwd ? cdb_value : '0);
    return o;
  endfunction
  function automatic rs_operand_t wake_operand(input rs_operand_t o,
                                               input logic cdb_valid,
                                               input logic [ROB_TAG_LEN-1:0] cdb_tag,
                                               input logic [XLEN-1:0] cdb_value);
    rs_operand_t w;
    logic hit;
    hit = !o.ready && cdb_valid && (o.tag == cdb_tag);
    w = o;
    w.ready = o.ready || hit;
    w.value = hit ? cdb_value : o.value;
    return w;
  endfunction
endpackage

// File: rtl/reservation_station_select.sv
// rs_select: lowest-index priority encoder returning the first set request and whether any is set.
module rs_select #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic          any,
  output logic [IW-1:0] idx
);
  always_comb begin
    any = |req;
    idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req[i]) idx = IW'(i);
  end
endmodule

// File: rtl/reservation_station.sv
// reservation_station: Tomasulo RS with CDB wakeup, lowest-index select and single-branch kill/resolve.
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int RS_SIZE = RS_SIZE_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   dispatch_valid,
  input  logic [PAYLOAD_W-1:0]   dispatch_op,
  input  logic [ROB_TAG_LEN-1:0] dispatch_rob,
  input  maptable_packet_t       rs1_map,
  input  maptable_packet_t       rs2_map,
  input  logic [XLEN-1:0]        rs1_value,
  input  logic [XLEN-1:0]        rs2_value,
  input  logic                   cdb_valid,
  input  logic [ROB_TAG_LEN-1:0] cdb_tag,
  input  logic [XLEN-1:0]        cdb_value,
  input  logic                   branch_detected,
  input  logic                   resolve,
  input  logic                   kill,
  input  logic                   issue_ready,
  output logic                   rs_full,
  output logic                   issue_valid,
  output rs_issue_packet_t       issue_packet
);
  localparam int IW = $clog2(RS_SIZE);
  rs_entry_t [RS_SIZE-1:0] entries_q, entries_d;
  logic branch_pending_q, branch_pending_d;
  logic [RS_SIZE-1:0] free_vec, ready_vec;
  logic [IW-1:0] free_idx, issue_idx;
  logic any_free, fire, do_dispatch;
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      free_vec[i] = !entries_q[i].valid;
      ready_vec[i] = entries_q[i].valid && entries_q[i].src1.ready && entries_q[i].src2.ready;
    end
  end
  rs_select #(.N(RS_SIZE), .IW(IW)) u_free_sel (.req(free_vec), .any(any_free), .idx(free_idx));
  rs_select #(.N(RS_SIZE), .IW(IW)) u_issue_sel (.req(ready_vec), .any(issue_valid), .idx(issue_idx));
  assign rs_full = !any_free;
  always_comb begin
    issue_packet = '0;
    if (issue_valid) begin
      issue_packet.op = entries_q[issue_idx].op;
      issue_packet.rob = entries_q[issue_idx].rob;
      issue_packet.rs1_value = entries_q[issue_idx].src1.value;
      issue_packet.rs2_value = entries_q[issue_idx].src2.value;
    end
  end
  // A dispatch racing a kill of the pending branch is on the wrong path and is dropped
  assign fire = issue_valid && issue_ready;
  assign do_dispatch = dispatch_valid && any_free && !(kill && branch_pending_q);
  always_comb begin
    entries_d = entries_q;
    for (int i = 0; i < RS_SIZE; i++) begin
      entries_d[i].src1 = wake_operand(entries_q[i].src1, cdb_valid, cdb_tag, cdb_value);
      entries_d[i].src2 = wake_operand(entries_q[i].src2, cdb_valid, cdb_tag, cdb_value);
      if ((fire && issue_idx == IW'(i)) || (kill && entries_q[i].spec)) entries_d[i].valid = 1'b0;
      if (resolve) entries_d[i].spec = 1'b0;
    end
    if (do_dispatch)
      entries_d[free_idx] = '{valid: 1'b1,
                              spec:  branch_pending_q && !resolve && !kill,
                              op:    dispatch_op,
                              rob:   dispatch_rob,
                              src1:  dispatch_operand(rs1_map, rs1_value, cdb_valid, cdb_tag, cdb_value),
                              src2:  dispatch_operand(rs2_map, rs2_value, cdb_valid, cdb_tag, cdb_value)};
    branch_pending_d = (kill || resolve) ? 1'b0 : (branch_detected ? 1'b1 : branch_pending_q);
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      entries_q <= '0;
      branch_pending_q <= 1'b0;
    end else begin
      entries_q <= entries_d;
      branch_pending_q <= branch_pending_d;
    end
  end
endmodule

// File: tb/tb_reservation_station.sv
// tb_reservation_station: directed spec scenarios plus randomized traffic checked against an array model.
module tb_reservation_station;
  import reservation_station_pkg::*;
  localparam int N = 4;
  logic clock = 1'b0, reset = 1'b0;
  logic dispatch_valid = 1'b0, cdb_valid = 1'b0, branch_detected = 1'b0;
  logic resolve = 1'b0, kill = 1'b0, issue_ready = 1'b0;
  logic [PAYLOAD_W-1:0] dispatch_op = '0;
  logic [ROB_TAG_LEN-1:0] dispatch_rob = '0, cdb_tag = '0;
  maptable_packet_t rs1_map = '0, rs2_map = '0;
  logic [XLEN-1:0] rs1_value = '0, rs2_value = '0, cdb_value = '0;
  logic rs_full, issue_valid;
  rs_issue_packet_t issue_packet;
  int checks = 0, errors = 0;
  bit m_v[N], m_s[N], m_r1[N], m_r2[N], m_pend;
  logic [PAYLOAD_W-1:0] m_op[N];
  logic [ROB_TAG_LEN-1:0] m_rob[N], m_t1[N], m_t2[N];
  logic [XLEN-1:0] m_x1[N], m_x2[N];

  always #5 clock = ~clock;

  reservation_station #(.RS_SIZE(N)) dut (
    .clock(clock), .reset(reset), .dispatch_valid(dispatch_valid), .dispatch_op(dispatch_op),
    .dispatch_rob(dispatch_rob), .rs1_map(rs1_map), .rs2_map(rs2_map), .rs1_value(rs1_value),
    .rs2_value(rs2_value), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .branch_detected(branch_detected), .resolve(resolve), .kill(kill), .issue_ready(issue_ready),
    .rs_full(rs_full), .issue_valid(issue_valid), .issue_packet(issue_packet));

  // Protocol rules the bench itself must respect
  always @(negedge clock) begin
    if (reset) begin
      assert (!(dispatch_valid && rs_full)) else begin errors++; $error("FAIL dispatch_while_full: dispatch_valid=1 rs_full=1 required no dispatch"); end
      assert (!(kill && resolve)) else begin errors++; $error("FAIL kill_resolve_exclusive: both asserted"); end
    end
  end

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(m_v[i]);
    return c;
  endfunction

  function automatic int m_first_ready();
    for (int i = 0; i < N; i++) if (m_v[i] && m_r1[i] && m_r2[i]) return i;
    return -1;
  endfunction

  task automatic chk64(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin errors++; $error("FAIL %s: got %0h expected %0h", tag, got, exp); end
  endtask

  task automatic check_model(input string tag);
    int r;
    r = m_first_ready();
    chk64({tag, " rs_full"}, 64'(rs_full), 64'(m_count() == N));
    chk64({tag, " issue_valid"}, 64'(issue_valid), 64'(r >= 0));
    if (r >= 0) begin
      chk64({tag, " op"}, 64'(issue_packet.op), 64'(m_op[r]));
      chk64({tag, " rob"}, 64'(issue_packet.rob), 64'(m_rob[r]));
      chk64({tag, " rs1_value"}, issue_packet.rs1_value, m_x1[r]);
      chk64({tag, " rs2_value"}, issue_packet.rs2_value, m_x2[r]);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin m_v[i] = 0; m_s[i] = 0; end
    m_pend = 0;
  endtask

  // Applies one clock edge of the spec's rules to the model using the current inputs
  task automatic model_clock();
    int ri, f;
    ri = m_first_ready();
    f = -1;
    for (int i = N - 1; i >= 0; i--) if (!m_v[i]) f = i;
    for (int i = 0; i < N; i++) if (m_v[i] && cdb_valid) begin
      if (!m_r1[i] && m_t1[i] == cdb_tag) begin m_r1[i] = 1; m_x1[i] = cdb_value; end
      if (!m_r2[i] && m_t2[i] == cdb_tag) begin m_r2[i] = 1; m_x2[i] = cdb_value; end
    end
    if (ri >= 0 && issue_ready) m_v[ri] = 0;
    for (int i = 0; i < N; i++) begin
      if (kill && m_s[i]) m_v[i] = 0;
      if (resolve) m_s[i] = 0;
    end
    if (dispatch_valid && f >= 0 && !(kill && m_pend)) begin
      m_v[f] = 1; m_s[f] = m_pend && !resolve && !kill;
      m_op[f] = dispatch_op; m_rob[f] = dispatch_rob;
      m_t1[f] = rs1_map.rob_tag_val; m_t2[f] = rs2_map.rob_tag_val;
      if (rs1_map.rob_tag_val == 0 || rs1_map.rob_tag_ready) begin m_r1[f] = 1; m_x1[f] = rs1_value; end
      else if (cdb_valid && cdb_tag == rs1_map.rob_tag_val) begin m_r1[f] = 1; m_x1[f] = cdb_value; end
      else m_r1[f] = 0;
      if (rs2_map.rob_tag_val == 0 || rs2_map.rob_tag_ready) begin m_r2[f] = 1; m_x2[f] = rs2_value; end
      else if (cdb_valid && cdb_tag == rs2_map.rob_tag_val) begin m_r2[f] = 1; m_x2[f] = cdb_value; end
      else m_r2[f] = 0;
    end
    m_pend = (kill || resolve) ? 0 : (branch_detected ? 1 : m_pend);
  endtask

  task automatic step(input string tag);
    check_model(tag);
    model_clock();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    dispatch_valid = 0; cdb_valid = 0; branch_detected = 0; resolve = 0; kill = 0;
  endtask

  task automatic dispatch(input int rob, input int t1, input bit r1, input logic [63:0] v1,
                          input int t2, input bit r2, input logic [63:0] v2);
    dispatch_valid = 1; dispatch_op = $urandom(); dispatch_rob = ROB_TAG_LEN'(rob);
    rs1_map = '{rob_tag_val: ROB_TAG_LEN'(t1), rob_tag_ready: r1}; rs1_value = v1;
    rs2_map = '{rob_tag_val: ROB_TAG_LEN'(t2), rob_tag_ready: r2}; rs2_value = v2;
  endtask

  task automatic cdb(input int tag, input logic [63:0] v);
    cdb_valid = 1; cdb_tag = ROB_TAG_LEN'(tag); cdb_value = v;
  endtask

  // Drops reset mid-cycle and checks outputs clear before any clock edge
  task automatic hard_reset(input string tag);
    idle(); issue_ready = 0;
    #2 reset = 0;
    #1;
    model_reset();
    chk64({tag, " rst issue_valid"}, 64'(issue_valid), 64'(0));
    chk64({tag, " rst rs_full"}, 64'(rs_full), 64'(0));
    checks++;
    assert (issue_packet === '0) else begin errors++; $error("FAIL %s rst issue_packet: got %0h expected 0", tag, issue_packet); end
    @(posedge clock); #1;
    reset = 1;
    @(posedge clock); #1;
  endtask

  initial begin
    int r;
    model_reset();
    hard_reset("init");

    // Basic flow
    issue_ready = 1;
    dispatch(1, 0, 0, 64'h11, 3, 1, 64'h55); step("basic dispatch");
    idle();
    chk64("basic issue_valid", 64'(issue_valid), 64'(1));
    chk64("basic rs1_value", issue_packet.rs1_value, 64'h11);
    chk64("basic rs2_value", issue_packet.rs2_value, 64'h55);
    step("basic issue");
    chk64("basic freed issue_valid", 64'(issue_valid), 64'(0));
    chk64("basic rs_full", 64'(rs_full), 64'(0));

    // Wakeup
    dispatch(2, 5, 0, 64'h0, 6, 0, 64'h0); step("wake dispatch");
    idle(); cdb(5, 64'h10); step("wake cdb5");
    chk64("wake after tag5", 64'(issue_valid), 64'(0));
    cdb(6, 64'h20); step("wake cdb6");
    idle();
    chk64("wake issue_valid", 64'(issue_valid), 64'(1));
    chk64("wake rs1_value", issue_packet.rs1_value, 64'h10);
    chk64("wake rs2_value", issue_packet.rs2_value, 64'h20);
    step("wake issue");

    // Forwarding at dispatch
    dispatch(3, 7, 0, 64'h0, 0, 0, 64'h99); cdb(7, 64'hAB); step("fwd dispatch");
    idle();
    chk64("fwd issue_valid", 64'(issue_valid), 64'(1));
    chk64("fwd rs1_value", issue_packet.rs1_value, 64'hAB);
    step("fwd issue");

    // Full and back-pressure
    issue_ready = 0;
    for (int k = 0; k < 4; k++) begin dispatch(4 + k, 8 + k, 0, 0, 0, 0, 64'(k)); step("full dispatch"); end
    idle();
    chk64("full rs_full", 64'(rs_full), 64'(1));
    chk64("full issue_valid", 64'(issue_valid), 64'(0));
    cdb(11, 64'h3); step("full cdb11");
    cdb(9, 64'h1); step("full cdb9");
    idle();
    chk64("bp rob", 64'(issue_packet.rob), 64'(5));
    step("bp hold");
    chk64("bp held rob", 64'(issue_packet.rob), 64'(5));
    issue_ready = 1; step("bp release");
    chk64("bp next rob", 64'(issue_packet.rob), 64'(7));
    chk64("bp rs_full", 64'(rs_full), 64'(0));
    step("bp drain");
    hard_reset("after full");

    // Kill
    dispatch(1, 20, 0, 0, 0, 0, 0); branch_detected = 1; step("kill branch");
    idle(); dispatch(2, 21, 0, 0, 0, 0, 0); step("kill spec1");
    dispatch(3, 22, 0, 0, 0, 0, 0); step("kill spec2");
    idle(); kill = 1; step("kill");
    idle();
    chk64("kill rs_full", 64'(rs_full), 64'(0));
    dispatch(4, 23, 0, 0, 0, 0, 0); step("kill refill1");
    dispatch(5, 24, 0, 0, 0, 0, 0); step("kill refill2");
    dispatch(6, 25, 0, 0, 0, 0, 0); step("kill refill3");
    idle();
    chk64("kill full again", 64'(rs_full), 64'(1));
    cdb(23, 64'h77); step("kill wake slot1");
    idle();
    chk64("kill slot1 rob", 64'(issue_packet.rob), 64'(4));
    step("kill end");
    hard_reset("after kill");

    // Resolve variant
    dispatch(1, 20, 0, 0, 0, 0, 0); branch_detected = 1; step("res branch");
    idle(); dispatch(2, 21, 0, 0, 0, 0, 0); step("res spec1");
    dispatch(3, 22, 0, 0, 0, 0, 0); step("res spec2");
    idle(); resolve = 1; step("resolve");
    idle(); kill = 1; step("kill after resolve");
    idle(); dispatch(4, 23, 0, 0, 0, 0, 0); step("res refill");
    idle();
    chk64("res rs_full", 64'(rs_full), 64'(1));
    cdb(22, 64'h5); step("res wake");
    idle();
    chk64("res kept rob", 64'(issue_packet.rob), 64'(3));
    step("res end");

    // Async reset with three valid entries
    hard_reset("pre async");
    dispatch(1, 0, 0, 64'hA, 0, 0, 64'hB); step("async d1");
    dispatch(2, 26, 0, 0, 0, 0, 0); step("async d2");
    dispatch(3, 27, 0, 0, 0, 0, 0); step("async d3");
    idle();
    chk64("async pre issue_valid", 64'(issue_valid), 64'(1));
    hard_reset("async");

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      idle();
      issue_ready = ($urandom_range(0, 3) != 0);
      if (m_count() < N && $urandom_range(0, 2) != 0)
        dispatch($urandom_range(1, 31), $urandom_range(0, 7), 1'($urandom_range(0, 1)), {$urandom(), $urandom()},
                 $urandom_range(0, 7), 1'($urandom_range(0, 1)), {$urandom(), $urandom()});
      if ($urandom_range(0, 1) != 0) cdb($urandom_range(1, 7), {$urandom(), $urandom()});
      r = $urandom_range(0, 15);
      if (r == 0 && !m_pend) branch_detected = 1;
      else if (r == 1 && m_pend) kill = 1;
      else if (r == 2 && m_pend) resolve = 1;
      step("rand");
    end
    idle();
    check_model("final");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
